// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter indices S..Z, element encoding, code table and decoder FSM states.
// The same code table can drive the transmitter LUT.
package morse_pkg;

  localparam int MAX_ELEMS = 4;

  localparam logic [2:0] LTR_S = 3'd0;
  localparam logic [2:0] LTR_T = 3'd1;
  localparam logic [2:0] LTR_U = 3'd2;
  localparam logic [2:0] LTR_V = 3'd3;
  localparam logic [2:0] LTR_W = 3'd4;
  localparam logic [2:0] LTR_X = 3'd5;
  localparam logic [2:0] LTR_Y = 3'd6;
  localparam logic [2:0] LTR_Z = 3'd7;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  // Pattern holds the first element in the most significant used bit.
  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pat;
  } morse_code_t;

  localparam morse_code_t CODE_S = {3'd3, 4'b0000};
  localparam morse_code_t CODE_T = {3'd1, 4'b0001};
  localparam morse_code_t CODE_U = {3'd3, 4'b0001};
  localparam morse_code_t CODE_V = {3'd4, 4'b0001};
  localparam morse_code_t CODE_W = {3'd3, 4'b0011};
  localparam morse_code_t CODE_X = {3'd4, 4'b1001};
  localparam morse_code_t CODE_Y = {3'd4, 4'b1011};
  localparam morse_code_t CODE_Z = {3'd4, 4'b1100};

  typedef enum logic [2:0] {IDLE, MARK, SPACE, DRAIN, EMIT} dec_state_t;

  function automatic morse_code_t code_of(input logic [2:0] idx);
    case (idx)
      LTR_S:   code_of = CODE_S;
      LTR_T:   code_of = CODE_T;
      LTR_U:   code_of = CODE_U;
      LTR_V:   code_of = CODE_V;
      LTR_W:   code_of = CODE_W;
      LTR_X:   code_of = CODE_X;
      LTR_Y:   code_of = CODE_Y;
      default: code_of = CODE_Z;
    endcase
  endfunction

  // Returns {hit, index}.
  function automatic logic [3:0] morse_lookup(input logic [2:0] len, input logic [3:0] pat);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (code_of(3'(i)) == {len, pat}) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_tick_gen.sv
// Morse time-unit tick: one-clock pulse every CLK_PER_UNIT clocks.
module morse_tick_gen #(
  parameter int CLK_PER_UNIT = 2500000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_PER_UNIT > 2) ? $clog2(CLK_PER_UNIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_PER_UNIT - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      cnt_reg <= '0;
    else if (cnt_reg == '0)
      cnt_reg <= RELOAD;
    else
      cnt_reg <= cnt_reg - CW'(1);
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: samples sig_in once per unit, collects dots/dashes, decodes S..Z on a letter gap.
// Optional MORSE_DEC_STICKY_ERR_EN turns error_out into a level held until reset.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int CLK_PER_UNIT = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sig_in,
  output logic [2:0] letter_out,
  output logic       valid_out,
  output logic       error_out,
  output logic       busy
);

  logic       tick;
  logic [1:0] sync_reg;
  logic       sample;

  dec_state_t state_reg, state_next;
  logic [2:0] run_cnt_reg, run_cnt_next;
  logic [2:0] elem_cnt_reg, elem_cnt_next;
  logic [3:0] pat_reg, pat_next;
  logic       err_flag_reg, err_flag_next;
  logic [2:0] letter_reg;
  logic [3:0] lookup;
  logic       good_emit;
  logic       bad_emit;
`ifdef MORSE_DEC_STICKY_ERR_EN
  logic       sticky_err_reg;
`endif

  morse_tick_gen #(.CLK_PER_UNIT(CLK_PER_UNIT)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign sample = sync_reg[1];

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg     <= 2'b00;
      state_reg    <= IDLE;
      run_cnt_reg  <= 3'd0;
      elem_cnt_reg <= 3'd0;
      pat_reg      <= 4'd0;
      err_flag_reg <= 1'b0;
      letter_reg   <= 3'd0;
`ifdef MORSE_DEC_STICKY_ERR_EN
      sticky_err_reg <= 1'b0;
`endif
    end else begin
      sync_reg     <= {sync_reg[0], sig_in};
      state_reg    <= state_next;
      run_cnt_reg  <= run_cnt_next;
      elem_cnt_reg <= elem_cnt_next;
      pat_reg      <= pat_next;
      err_flag_reg <= err_flag_next;
      if (good_emit) letter_reg <= lookup[2:0];
`ifdef MORSE_DEC_STICKY_ERR_EN
      if (bad_emit) sticky_err_reg <= 1'b1;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    run_cnt_next  = run_cnt_reg;
    elem_cnt_next = elem_cnt_reg;
    pat_next      = pat_reg;
    err_flag_next = err_flag_reg;
    case (state_reg)
      IDLE: begin
        if (tick && sample) begin
          state_next   = MARK;
          run_cnt_next = 3'd1;
        end
      end
      MARK: begin
        if (tick) begin
          if (sample) begin
            run_cnt_next = sat_inc(run_cnt_reg);
            if (run_cnt_reg == 3'd3) begin
              err_flag_next = 1'b1;
              state_next    = DRAIN;
              run_cnt_next  = 3'd0;
            end
          end else if (elem_cnt_reg == 3'(MAX_ELEMS)) begin
            // The closing space already counts toward the drain gap.
            err_flag_next = 1'b1;
            state_next    = DRAIN;
            run_cnt_next  = 3'd1;
          end else begin
            pat_next      = {pat_reg[2:0], (run_cnt_reg == 3'd1) ? DOT : DASH};
            elem_cnt_next = elem_cnt_reg + 3'd1;
            state_next    = SPACE;
            run_cnt_next  = 3'd1;
          end
        end
      end
      SPACE: begin
        if (tick) begin
          if (sample) begin
            state_next   = MARK;
            run_cnt_next = 3'd1;
          end else begin
            run_cnt_next = sat_inc(run_cnt_reg);
            if (run_cnt_reg == 3'd2) state_next = EMIT;
          end
        end
      end
      DRAIN: begin
        if (tick) begin
          if (sample) begin
            run_cnt_next = 3'd0;
          end else begin
            run_cnt_next = sat_inc(run_cnt_reg);
            if (run_cnt_reg == 3'd2) state_next = EMIT;
          end
        end
      end
      EMIT: begin
        state_next    = IDLE;
        run_cnt_next  = 3'd0;
        elem_cnt_next = 3'd0;
        pat_next      = 4'd0;
        err_flag_next = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lookup     = morse_lookup(elem_cnt_reg, pat_reg);
    good_emit  = (state_reg == EMIT) && lookup[3] && !err_flag_reg;
    bad_emit   = (state_reg == EMIT) && !good_emit;
    valid_out  = good_emit;
    letter_out = good_emit ? lookup[2:0] : letter_reg;
    busy       = (state_reg != IDLE);
`ifdef MORSE_DEC_STICKY_ERR_EN
    error_out  = sticky_err_reg || bad_emit;
`else
    error_out  = bad_emit;
`endif
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: table of unit-step light patterns, scoreboard of expected strobes.
module tb_morse_decoder;

  localparam int CPU = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       sig_in;
  logic [2:0] letter_out;
  logic       valid_out;
  logic       error_out;
  logic       busy;

  morse_decoder #(.CLK_PER_UNIT(CPU)) dut (
    .clock      (clock),
    .reset      (reset),
    .sig_in     (sig_in),
    .letter_out (letter_out),
    .valid_out  (valid_out),
    .error_out  (error_out),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] bits;
    int          len;
    logic        is_err;
    logic [2:0]  letter;
  } vec_t;

  typedef struct {
    logic       is_err;
    logic [2:0] letter;
  } exp_t;

  vec_t       tbl[12];
  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [2:0] last_letter = 3'd0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.is_err = v.is_err;
    if (v.is_err) begin
      e.letter = last_letter;
    end else begin
      e.letter = v.letter;
      last_letter = v.letter;
    end
    sb.push_back(e);
  endtask

  task automatic drive_units(input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      sig_in = bits[i];
      repeat (CPU) @(negedge clock);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    push_exp(v);
    drive_units(v.bits, v.len);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d strobes still pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic idle_check_busy(input string name);
    sig_in = 1'b0;
    repeat (CPU) @(negedge clock);
    chk(name, int'(busy), 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_letter"}, int'(letter_out), 0);
    chk({tag, "_valid"}, int'(valid_out), 0);
    chk({tag, "_error"}, int'(error_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  task automatic monitor();
    exp_t e;
    logic err_ev;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_valid = 1'b0;
        prev_err   = 1'b0;
      end else begin
`ifdef MORSE_DEC_STICKY_ERR_EN
        err_ev = error_out && !prev_err;
`else
        err_ev = error_out;
        if (valid_out && error_out) chk("both_strobes", 1, 0);
`endif
        if (valid_out && prev_valid) chk("valid_width", 2, 1);
        if (valid_out || err_ev) begin
          if (sb.size() == 0) begin
            chk("unexpected_strobe", int'(letter_out), -1);
          end else begin
            e = sb.pop_front();
            chk("strobe_kind_err", int'(err_ev), int'(e.is_err));
            chk("strobe_letter", int'(letter_out), int'(e.letter));
          end
        end
        prev_valid = valid_out;
        prev_err   = error_out;
      end
    end
  endtask

  task automatic main();
    vec_t v;
    tbl[0]  = '{16'b0000000010101000,  8, 1'b0, 3'd0};  // S
    tbl[1]  = '{16'b0000000000111000,  6, 1'b0, 3'd1};  // T
    tbl[2]  = '{16'b0000001010111000, 10, 1'b0, 3'd2};  // U
    tbl[3]  = '{16'b0000101010111000, 12, 1'b0, 3'd3};  // V
    tbl[4]  = '{16'b0000101110111000, 12, 1'b0, 3'd4};  // W
    tbl[5]  = '{16'b0011101010111000, 14, 1'b0, 3'd5};  // X
    tbl[6]  = '{16'b1110101110111000, 16, 1'b0, 3'd6};  // Y
    tbl[7]  = '{16'b0011101110101000, 14, 1'b0, 3'd7};  // Z
    tbl[8]  = '{16'b0000000011110000,  8, 1'b1, 3'd0};  // 4-unit mark
    tbl[9]  = '{16'b0001010101010000, 13, 1'b1, 3'd0};  // five dots
    tbl[10] = '{16'b0000000010101000,  8, 1'b0, 3'd0};  // S after error
    tbl[11] = '{16'b0000000001110000,  7, 1'b0, 3'd1};  // T, 1110000

    reset  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clock);
    check_cleared("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    drive_vec(tbl[11]);
    wait_drain();
    idle_check_busy("busy_after_T");

    for (int i = 0; i < 11; i++) drive_vec(tbl[i]);
    wait_drain();
    idle_check_busy("busy_after_table");

    // Reset in the middle of V after a nonzero letter is held.
    drive_vec(tbl[6]);
    wait_drain();
    drive_units(16'b0000000000101010, 6);
    chk("busy_mid_V", int'(busy), 1);
    reset = 1'b0;
    @(negedge clock);
    check_cleared("mid_reset");
    last_letter = 3'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    v = tbl[0];
    drive_vec(v);
    wait_drain();
    idle_check_busy("busy_after_reset_S");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    fork
      monitor();
      main();
    join_any
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
